two_reg_fifo: RTL and testbench



---
 rtl/two_reg_fifo_if.sv | 33 +++
 rtl/two_reg_fifo.sv | 80 ++++++++
 tb/tb_two_reg_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/two_reg_fifo_if.sv
// Handshake bundle for the two-entry elastic buffer.
// The master side writes and reads entries; the slave side is the FIFO itself.
interface two_reg_fifo_if #(
  parameter int WIDTH = 8
);
  logic             iWrEn;
  logic [WIDTH-1:0] iWrDat;
  logic             iRdEn;
  logic             oFul;
  logic             oEmpty;
  logic [1:0]       oDatVld;
  logic [WIDTH-1:0] oRdDat;

  modport master (
    output iWrEn,
    output iWrDat,
    output iRdEn,
    input  oFul,
    input  oEmpty,
    input  oDatVld,
    input  oRdDat
  );

  modport slave (
    input  iWrEn,
    input  iWrDat,
    input  iRdEn,
    output oFul,
    output oEmpty,
    output oDatVld,
    output oRdDat
  );
endinterface

// File: rtl/two_reg_fifo.sv
// Two-entry first-word-fall-through FIFO made of a head and a tail register.
// The head entry is always shown on oRdDat; all outputs come from registers.
// Optional feature macro: TWO_REG_FIFO_PASS_EN -- when defined, a write is
// accepted while full as long as a read is accepted in the same cycle.
module two_reg_fifo #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  two_reg_fifo_if.slave bus
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             headVld;
  logic             tailVld;
  logic             wrAcc;
  logic             rdAcc;

`ifdef TWO_REG_FIFO_PASS_EN
  assign wrAcc = bus.iWrEn & (~tailVld | bus.iRdEn);
`else
  assign wrAcc = bus.iWrEn & ~tailVld;
`endif
  assign rdAcc = bus.iRdEn & headVld;

  assign bus.oDatVld = {tailVld, headVld};
  assign bus.oEmpty  = ~headVld;
  assign bus.oFul    = tailVld;
  assign bus.oRdDat  = head;

  // Occupancy-driven update of the two slots; data registers are never
  // cleared by a read, only the valid bits drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      headVld <= 1'b0;
      tailVld <= 1'b0;
    end else begin
      case ({tailVld, headVld})
        2'b00: begin
          if (wrAcc) begin
            head    <= bus.iWrDat;
            headVld <= 1'b1;
          end
        end
        2'b01: begin
          case ({wrAcc, rdAcc})
            2'b10: begin
              tail    <= bus.iWrDat;
              tailVld <= 1'b1;
            end
            2'b01: begin
              headVld <= 1'b0;
            end
            2'b11: begin
              head <= bus.iWrDat;
            end
            default: begin
            end
          endcase
        end
        2'b11: begin
          if (rdAcc) begin
            head <= tail;
            if (wrAcc) begin
              tail <= bus.iWrDat;
            end else begin
              tailVld <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_reg_fifo.sv
// Self-checking bench for two_reg_fifo: directed vectors, with a scoreboard
// queue of expected read data popped by a monitor on every accepted read.
module tb_two_reg_fifo;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;
  logic [7:0] expQ [$];

  two_reg_fifo_if #(.WIDTH(8)) bus ();

  two_reg_fifo #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of enables/data, let the rising edge take it, then idle.
  task automatic applyStimulus(input logic wr, input logic [7:0] dat, input logic rd);
    bus.iWrEn  = wr;
    bus.iWrDat = dat;
    bus.iRdEn  = rd;
    @(posedge clk);
    #1;
    bus.iWrEn = 1'b0;
    bus.iRdEn = 1'b0;
  endtask

  // Compare the flag group against expected occupancy.
  task automatic checkOutput(input string name, input logic [1:0] expVld,
                             input logic expFul, input logic expEmpty);
    checkCount++;
    if (bus.oDatVld !== expVld || bus.oFul !== expFul || bus.oEmpty !== expEmpty) begin
      failCount++;
      $display("[TB] FAIL %s: vld=%b ful=%b empty=%b, expected vld=%b ful=%b empty=%b",
               name, bus.oDatVld, bus.oFul, bus.oEmpty, expVld, expFul, expEmpty);
    end
  endtask

  // Compare the head data port against an expected value.
  task automatic checkData(input string name, input logic [7:0] expDat);
    checkCount++;
    if (bus.oRdDat !== expDat) begin
      failCount++;
      $display("[TB] FAIL %s: rdDat=%h, expected %h", name, bus.oRdDat, expDat);
    end
  endtask

  // Monitor: every accepted read consumes the head, which must match the
  // oldest expected entry in the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.iRdEn === 1'b1 && bus.oEmpty === 1'b0) begin
        checkCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL readUnexpected: got %h, expected no data", bus.oRdDat);
        end else begin
          logic [7:0] expDat;
          expDat = expQ.pop_front();
          if (bus.oRdDat !== expDat) begin
            failCount++;
            $display("[TB] FAIL readData: got %h, expected %h", bus.oRdDat, expDat);
          end
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    checkCount = 0;
    failCount  = 0;
    bus.iWrEn  = 1'b0;
    bus.iWrDat = '0;
    bus.iRdEn  = 1'b0;
    rst        = 1'b0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 5; i++) begin
      bus.iWrEn  = 1'($urandom_range(0, 1));
      bus.iRdEn  = 1'($urandom_range(0, 1));
      bus.iWrDat = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      checkOutput("resetFlags", 2'b00, 1'b0, 1'b1);
      checkData("resetData", 8'h00);
    end
    bus.iWrEn = 1'b0;
    bus.iRdEn = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("afterReset", 2'b00, 1'b0, 1'b1);
    checkData("afterResetData", 8'h00);

    // Fill, overflow attempt, drain.
    expQ.push_back(8'h01);
    expQ.push_back(8'h02);
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("fill1", 2'b01, 1'b0, 1'b0);
    checkData("fill1Data", 8'h01);
    applyStimulus(1'b1, 8'h02, 1'b0);
    checkOutput("fill2", 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    checkOutput("overflow", 2'b11, 1'b1, 1'b0);
    checkData("overflowData", 8'h01);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain1", 2'b01, 1'b0, 1'b0);
    checkData("drain1Data", 8'h02);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain2", 2'b00, 1'b0, 1'b1);

    // Streaming at occupancy one.
    for (int i = 0; i < 21; i++) expQ.push_back(8'h10 + 8'(i));
    applyStimulus(1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h11 + 8'(i), 1'b1);
      checkOutput("stream", 2'b01, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("streamDrain", 2'b00, 1'b0, 1'b1);

    // Simultaneous read and write while full.
    expQ.push_back(8'hA0);
    expQ.push_back(8'hA1);
`ifdef TWO_REG_FIFO_PASS_EN
    expQ.push_back(8'hA2);
`endif
    applyStimulus(1'b1, 8'hA0, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b0);
    checkOutput("fullPre", 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b1);
`ifdef TWO_REG_FIFO_PASS_EN
    checkOutput("fullPass", 2'b11, 1'b1, 1'b0);
    checkData("fullPassHead", 8'hA1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
`else
    checkOutput("fullNoPass", 2'b01, 1'b0, 1'b0);
    checkData("fullNoPassHead", 8'hA1);
    applyStimulus(1'b0, 8'h00, 1'b1);
`endif
    checkOutput("fullDrained", 2'b00, 1'b0, 1'b1);

    // Underflow: reads of an empty FIFO change nothing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("underflow", 2'b00, 1'b0, 1'b1);
`ifdef TWO_REG_FIFO_PASS_EN
      checkData("underflowStale", 8'hA2);
`else
      checkData("underflowStale", 8'hA1);
`endif
    end
    expQ.push_back(8'h55);
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkData("afterUnderflow", 8'h55);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Asynchronous reset while full.
    applyStimulus(1'b1, 8'hB0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0);
    checkOutput("preMidReset", 2'b11, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midReset", 2'b00, 1'b0, 1'b1);
    checkData("midResetData", 8'h00);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expQ.push_back(8'h7E);
    applyStimulus(1'b1, 8'h7E, 1'b0);
    checkOutput("postReset", 2'b01, 1'b0, 1'b0);
    checkData("postResetData", 8'h7E);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postResetDrain", 2'b00, 1'b0, 1'b1);

    // Every expected entry must have been read out.
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardLeft: %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
